// File: rtl/tensor_block_sequencer.sv
// tensor_block_sequencer: loads weights, streams activations into one tensor_block and collects its three accumulations
module tensor_block_sequencer #(
  parameter int LAT  = 7,
  parameter int SKEW = 2,
  parameter int KW   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [79:0]   w_data,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [79:0]   a_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res0,
  output logic [31:0]   res1,
  output logic [31:0]   res2,
  output logic          busy,
  output logic [79:0]   tb_data_in,
  output logic          tb_dot_unit_input_1_enable,
  output logic          tb_bank0_data_in_enable,
  output logic          tb_mux1_select,
  output logic          tb_bank1_data_in_enable,
  output logic          tb_cascade_out_select,
  output logic          tb_dot_unit_input_2_select,
  output logic [2:0]    tb_accumulator_input1_select,
  output logic [31:0]   tb_acc0_in,
  output logic [31:0]   tb_acc1_in,
  output logic [31:0]   tb_acc2_in,
  input  logic [31:0]   tb_acc0_out,
  input  logic [31:0]   tb_acc1_out,
  input  logic [31:0]   tb_acc2_out
);
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;
  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d, cnt_q, cnt_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic [LAT:1]  first_q, first_d, last_q, last_d;
  logic [31:0]   res0_q, res0_d, res1_q, res1_d, res2_q, res2_d;
  logic          w_ready_q, w_ready_d, a_ready_q, a_ready_d;
  logic          res_valid_q, res_valid_d, busy_q, busy_d;
  logic          a_acc, is_last;
  assign w_ready   = w_ready_q;
  assign a_ready   = a_ready_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign res0      = res0_q;
  assign res1      = res1_q;
  assign res2      = res2_q;
  assign tb_mux1_select             = 1'b0;
  assign tb_bank1_data_in_enable    = 1'b0;
  assign tb_cascade_out_select      = 1'b0;
  assign tb_dot_unit_input_2_select = 1'b0;
  assign tb_acc0_in = 32'd0;
  assign tb_acc1_in = 32'd0;
  assign tb_acc2_in = 32'd0;
  // Block-side drive: bubbles and idle states feed zeros; the dot input is frozen while weights load
  always_comb begin
    tb_data_in = (state_q == LOAD) ? w_data : (state_q == STREAM && a_valid) ? a_data : 80'h0;
    tb_dot_unit_input_1_enable   = state_q != LOAD;
    tb_bank0_data_in_enable      = state_q == LOAD && w_valid;
    tb_accumulator_input1_select = first_q[LAT-SKEW] ? 3'b000 : 3'b111;
  end
  // Next state, marker delay lines, beat counters and result capture
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    res0_d   = res0_q;
    res1_d   = res1_q;
    res2_d   = res2_q;
    a_acc    = state_q == STREAM && a_valid;
    is_last  = cnt_q == k_q - KW'(1);
    first_d  = {first_q[LAT-1:1], a_acc && cnt_q == '0};
    last_d   = {last_q[LAT-1:1], a_acc && is_last};
    case (state_q)
      IDLE: if (start) begin
        k_d     = (k_len == '0) ? KW'(1) : k_len;
        cnt_d   = '0;
        wcnt_d  = '0;
        state_d = LOAD;
      end
      LOAD: if (w_valid) begin
        wcnt_d  = wcnt_q + 2'd1;
        state_d = (wcnt_q == 2'd2) ? STREAM : LOAD;
      end
      STREAM: if (a_valid) begin
        cnt_d   = cnt_q + KW'(1);
        state_d = is_last ? DRAIN : STREAM;
      end
      DRAIN: if (last_q[LAT]) begin
        res0_d  = tb_acc0_out;
        res1_d  = tb_acc1_out;
        res2_d  = tb_acc2_out;
        state_d = DONE;
      end
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    w_ready_d   = state_d == LOAD;
    a_ready_d   = state_d == STREAM;
    res_valid_d = state_d == DONE;
    busy_d      = state_d != IDLE;
  end
  // Sequencer state with registered handshake outputs; reset drops in-flight markers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      first_q     <= '0;
      last_q      <= '0;
      res0_q      <= '0;
      res1_q      <= '0;
      res2_q      <= '0;
      w_ready_q   <= 1'b0;
      a_ready_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      first_q     <= first_d;
      last_q      <= last_d;
      res0_q      <= res0_d;
      res1_q      <= res1_d;
      res2_q      <= res2_d;
      w_ready_q   <= w_ready_d;
      a_ready_q   <= a_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end
endmodule

// File: doc/tensor_block_sequencer.md
# tensor_block_sequencer

Job-level controller that drives the control and data side of one `tensor_block` in non-cascaded mode and collects its three 32-bit accumulations. It loads three 80-bit weight vectors (10 × int8 lanes) into bank 0 and streams K activation vectors, feeding zeros on bubbles. It times the accumulator clear and result capture against the block's fixed pipeline, then returns res0..res2 over a valid/ready handshake. It sits between the layer scheduler (weight/activation streams) and a single `tensor_block` instance.

## Interface
- LAT, 7, cycles from `tb_data_in` accept edge to that vector's lane 1–8 products appearing on `tb_acc*_out` (comb)
- SKEW, 2, lanes 9–10 of a vector reach `tb_acc*_out` SKEW cycles earlier than lanes 1–8
- KW, 16, width of `k_len`

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  job request; sampled only in IDLE
- k_len  in  KW  activations per job; 0 is treated as 1; captured on start
- w_valid / w_ready  in / out  1 / 1  weight beat handshake
- w_data  in  80  weight vector
- a_valid / a_ready  in / out  1 / 1  activation beat handshake
- a_data  in  80  activation vector
- res_valid / res_ready  out / in  1 / 1  result handshake
- res0, res1, res2  out  32 each  accumulations; lane n pairs with bank0_reg n
- busy  out  1  high in every state except IDLE
- tb_data_in  out  80  to tensor_block `data_in` (combinational)
- tb_dot_unit_input_1_enable, tb_bank0_data_in_enable  out  1  combinational
- tb_mux1_select, tb_bank1_data_in_enable, tb_cascade_out_select, tb_dot_unit_input_2_select  out  1  tied 0
- tb_accumulator_input1_select  out  3  combinational, all bits equal
- tb_acc0_in, tb_acc1_in, tb_acc2_in  out  32  tied 0
- tb_acc0_out, tb_acc1_out, tb_acc2_out  in  32  from tensor_block

## Operation
- Reset values: state IDLE; w_ready = a_ready = res_valid = busy = 0; res0..2 = 0; marker delay lines cleared.
- IDLE: tb_data_in = 0, dot enable = 1 (flushes zeros). On start, latch K = max(k_len, 1), then go to LOAD.
- LOAD: w_ready = 1, tb_data_in = w_data, tb_bank0_data_in_enable = w_valid, dot enable = 0 (holds zero vector).
  - Count 3 accepted beats, then go to STREAM.
  - Beat order: beat0 ends in reg2 (res2), beat1 in reg1 (res1), beat2 in reg0 (res0).
- STREAM: a_ready = 1, dot enable = 1.
  - tb_data_in = a_data when a_valid, else 80'h0. Bubbles contribute zero, so the accumulator stays correct.
  - The first accepted beat pushes a FIRST marker; the K-th pushes a LAST marker. Then go to DRAIN.
- Markers travel in two LAT-deep shift registers that advance every cycle.
- tb_accumulator_input1_select = 3'b000 in the single cycle the FIRST marker is at depth LAT−SKEW, else 3'b111. This clears the accumulator by selecting acc_in = 0.
- DRAIN: tb_data_in = 0, dot enable = 1. When the LAST marker reaches depth LAT, register tb_acc0..2_out into res0..2 at that edge and go to DONE.
- DONE: res_valid = 1, results held stable, zeros still fed. On res_valid && res_ready, go to IDLE.
- Arithmetic: unsigned int8 lanes, no saturation. 32-bit sums wrap modulo 2^32 and are passed through unmodified.

## Timing
- Accept of activation beat at edge t: its lane 9–10 terms appear on tb_acc*_out in cycle t+LAT−SKEW; its lane 1–8 terms in cycle t+LAT.
- Clear cycle: t_first+LAT−SKEW. Capture edge: t_last+LAT. res_valid rises the cycle after capture.
- Minimum job length (zero stalls, K beats):
  - start edge → LOAD 1 cycle, 3 LOAD cycles, K STREAM cycles;
  - DRAIN until t_last+LAT;
  - DONE ≥ 1 cycle, then 1 cycle in IDLE before the next start.
- IDLE/DONE zero feed: at least LAT zero cycles separate jobs. The next job's clear therefore never overlaps the previous job's in-flight products.
- Reset mid-job: asynchronous return to IDLE, outputs to reset values, markers dropped. No partial res_valid.
- a_valid deasserting mid-STREAM: a zero beat is inserted and the K count does not advance.
- start while not IDLE: ignored.

## Test plan
- Weight beats with all bytes 1/2/3, K=4 activations with all bytes 1, no stalls → res0=120, res1=80, res2=40. Capture edge exactly t_last+7.
- Same job with a_valid toggling 1,0,1,0… → identical results. res_valid delayed by the number of bubbles.
- k_len=0, one activation with all bytes 8'hFF, weights with all bytes 8'hFF → K treated as 1, res0..2 = 10·65025 = 650250.
- Two back-to-back jobs, second with weights all 0 → second job returns res0..2 = 0, so no carry-over from job 1.
- reset pulsed on the 2nd STREAM cycle, then a fresh job with the first test's stimulus → busy=0 and res_valid=0 immediately after reset; the fresh job returns 120/80/40.
- res_ready held low 20 cycles in DONE → res_valid and res0..2 stay stable and start is ignored. The handshake completes on the first res_ready=1.
